// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared stall encodings, FSM states and stall bit indices for pipeline_ctrl
package pipe_pkg;

    localparam int STALL_W     = 6;
    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;
    localparam int STALL_MEMWB = 4;
    localparam int STALL_WB    = 5;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } pipe_state_t;

    // Stall choice once memory is known not to be pending.
    function automatic logic [STALL_W-1:0] run_priority(input logic halt,
                                                        input logic ex,
                                                        input logic id);
        if (halt)
            return STALL_ALL;
        else if (ex)
            return STALL_EX;
        else if (id)
            return STALL_ID;
        else
            return STALL_NONE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear, enable and saturation at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (en && (q != '1))
            q <= q + W'(1);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall sequencer for the five-stage pipeline with boot hold, mem timeout and halt
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall_req,
    input  logic        ex_stall_req,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        halt_req,
    input  logic        resume,
    output logic [5:0]  stall,
    output logic        mem_timeout,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cycles
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    pipe_state_t        state;
    logic [BOOT_W-1:0]  boot_cnt;
    logic [7:0]         tmo_cnt;
    logic               mem_pending;
    logic [5:0]         prio;
    logic               in_wait;
    logic               count_en;

    assign mem_pending = mem_req & ~mem_ack;
    assign prio        = run_priority(halt_req, ex_stall_req, id_stall_req);
    assign in_wait     = (state == ST_MEM_WAIT);
    assign state_o     = state;

    always_comb begin
        stall = STALL_ALL;
        if (!rst) begin
            case (state)
                ST_RUN:      stall = mem_pending ? STALL_MEM : prio;
                ST_MEM_WAIT: stall = mem_ack ? prio : STALL_MEM;
                default:     stall = STALL_ALL;
            endcase
        end
    end

    // Held at zero outside MEM_WAIT so it reads 0 in the first waiting cycle.
    sat_counter #(.W(8)) u_tmo_cnt (
        .clk (clk),
        .rst (rst),
        .clr (~in_wait),
        .en  (in_wait),
        .q   (tmo_cnt)
    );

    assign count_en = ((state == ST_RUN) || in_wait) && stall[STALL_PC];

    sat_counter #(.W(16)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (count_en),
        .q   (stall_cycles)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            boot_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    if (boot_cnt == BOOT_W'(BOOT_CYCLES - 1)) begin
                        state    <= ST_RUN;
                        boot_cnt <= '0;
                    end else begin
                        boot_cnt <= boot_cnt + BOOT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (mem_pending)
                        state <= ST_MEM_WAIT;
                    else if (halt_req)
                        state <= ST_HALT;
                end
                ST_MEM_WAIT: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (mem_ack) begin
                        state <= ST_RUN;
                    end else if (tmo_cnt == 8'(MEM_TIMEOUT - 1)) begin
                        state       <= ST_HALT;
                        mem_timeout <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state       <= ST_RUN;
                        mem_timeout <= 1'b0;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl against a cycle-level behavioural model
module tb_pipeline_ctrl;

    localparam int BOOT = 4;
    localparam int TMO  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_stall_req = 1'b0;
    logic        ex_stall_req = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ack = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [5:0]  stall;
    logic        mem_timeout;
    logic [1:0]  state_o;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.BOOT_CYCLES(BOOT), .MEM_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_stall_req (id_stall_req),
        .ex_stall_req (ex_stall_req),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .halt_req     (halt_req),
        .resume       (resume),
        .stall        (stall),
        .mem_timeout  (mem_timeout),
        .state_o      (state_o),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Model: mode 0 boot, 1 run, 2 waiting on memory, 3 halted.
    int m_mode = 0;
    int m_boot_left = BOOT;
    int m_wait_left = 0;
    int m_tmo = 0;
    int m_cnt = 0;

    function automatic logic [5:0] pick(input logic h, input logic e, input logic d);
        if (h) return 6'b111111;
        if (e) return 6'b001111;
        if (d) return 6'b000111;
        return 6'b000000;
    endfunction

    always @(negedge clk) begin
        logic [5:0] exp_stall;
        if (started) begin
            exp_stall = 6'b111111;
            if (!rst && m_mode == 1)
                exp_stall = (mem_req && !mem_ack) ? 6'b011111 : pick(halt_req, ex_stall_req, id_stall_req);
            else if (!rst && m_mode == 2)
                exp_stall = mem_ack ? pick(halt_req, ex_stall_req, id_stall_req) : 6'b011111;
            chk("m_stall", {10'd0, stall}, {10'd0, exp_stall});
            chk("m_state", {14'd0, state_o}, 16'(m_mode));
            chk("m_tmo", {15'd0, mem_timeout}, 16'(m_tmo));
            chk("m_cnt", stall_cycles, 16'(m_cnt));

            if (rst) begin
                m_mode = 0; m_boot_left = BOOT; m_tmo = 0; m_cnt = 0;
            end else begin
                if ((m_mode == 1 || m_mode == 2) && exp_stall[0] && m_cnt < 65535)
                    m_cnt++;
                case (m_mode)
                    0: begin
                        m_boot_left--;
                        if (m_boot_left == 0) m_mode = 1;
                    end
                    1: begin
                        if (mem_req && !mem_ack) begin
                            m_mode = 2; m_wait_left = TMO;
                        end else if (halt_req) begin
                            m_mode = 3;
                        end
                    end
                    2: begin
                        if (mem_ack) begin
                            m_mode = 1;
                        end else begin
                            m_wait_left--;
                            if (m_wait_left == 0) begin
                                m_mode = 3; m_tmo = 1;
                            end
                        end
                    end
                    default: begin
                        if (resume) begin
                            m_mode = 1; m_tmo = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) cyc();
        started = 1'b1;
        chk("rst_state", {14'd0, state_o}, 16'd0);
        chk("rst_stall", {10'd0, stall}, 16'h3f);
        chk("rst_cnt", stall_cycles, 16'd0);
        chk("rst_tmo", {15'd0, mem_timeout}, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < BOOT; i++) begin
            #2 chk("boot_stall", {10'd0, stall}, 16'h3f);
            cyc();
        end
        chk("run_stall", {10'd0, stall}, 16'h00);
        chk("run_state", {14'd0, state_o}, 16'd1);

        id_stall_req = 1'b1; ex_stall_req = 1'b1;
        #2 chk("ex_over_id", {10'd0, stall}, 16'h0f);
        cyc();
        ex_stall_req = 1'b0;
        #2 chk("id_only", {10'd0, stall}, 16'h07);
        cyc();
        id_stall_req = 1'b0;
        #2 chk("cnt_two", stall_cycles, 16'd2);

        mem_ack = 1'b1;
        #2 chk("stray_ack", {10'd0, stall}, 16'h00);
        resume = 1'b1;
        cyc();
        mem_ack = 1'b0; resume = 1'b0;
        chk("stray_ack_state", {14'd0, state_o}, 16'd1);

        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2 chk("mem_wait_stall", {10'd0, stall}, 16'h1f);
            cyc();
        end
        mem_ack = 1'b1;
        #2 chk("ack_stall", {10'd0, stall}, 16'h00);
        cyc();
        mem_ack = 1'b0; mem_req = 1'b0;
        chk("ack_state", {14'd0, state_o}, 16'd1);

        mem_req = 1'b1;
        repeat (1 + TMO) cyc();
        mem_req = 1'b0;
        chk("tmo_flag", {15'd0, mem_timeout}, 16'd1);
        chk("tmo_state", {14'd0, state_o}, 16'd3);
        chk("tmo_stall", {10'd0, stall}, 16'h3f);
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        chk("resume_state", {14'd0, state_o}, 16'd1);
        chk("resume_tmo", {15'd0, mem_timeout}, 16'd0);

        mem_req = 1'b1; halt_req = 1'b1;
        #2 chk("halt_vs_mem", {10'd0, stall}, 16'h1f);
        repeat (2) cyc();
        chk("halt_ignored", {14'd0, state_o}, 16'd2);
        chk("halt_ign_stall", {10'd0, stall}, 16'h1f);
        mem_ack = 1'b1;
        #2 chk("ack_halt_stall", {10'd0, stall}, 16'h3f);
        cyc();
        mem_ack = 1'b0; mem_req = 1'b0;
        chk("post_ack_run", {14'd0, state_o}, 16'd1);
        cyc();
        chk("post_ack_halt", {14'd0, state_o}, 16'd3);
        halt_req = 1'b0; resume = 1'b1;
        cyc();
        resume = 1'b0;

        id_stall_req = 1'b1;
        repeat (65540) cyc();
        id_stall_req = 1'b0;
        chk("cnt_sat", stall_cycles, 16'hffff);

        mem_req = 1'b1;
        repeat (2) cyc();
        chk("pre_rst_wait", {14'd0, state_o}, 16'd2);
        rst = 1'b1;
        #2 chk("rst_in_wait_stall", {10'd0, stall}, 16'h3f);
        cyc();
        mem_req = 1'b0;
        chk("rst_wait_state", {14'd0, state_o}, 16'd0);
        chk("rst_wait_cnt", stall_cycles, 16'd0);
        chk("rst_wait_tmo", {15'd0, mem_timeout}, 16'd0);
        rst = 1'b0;
        repeat (BOOT + 2) cyc();
        chk("reboot_state", {14'd0, state_o}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
